// File: rtl/atc_request_sequencer.sv
// -----------------------------------------------------------------------------
// atc_request_sequencer
//
// Initiator side of the direction/enable/signal handshake into the air-traffic
// controller. Per-direction aircraft requests are latched into a pending set;
// one pending direction is chosen by round-robin, presented on d with a
// one-cycle en strobe, and the sequencer then waits for the controller's
// one-hot acknowledge on signal. An acknowledged direction reserves the
// corridor for HOLD_CYCLES before the next request is served. An attempt
// with no acknowledge within ACK_TIMEOUT cycles is abandoned and reported.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   req[3:0]     in   per-direction request, sets pending[i]
//   signal[3:0]  in   controller acknowledge, one-hot on the granted direction
//   d[1:0]       out  direction presented to the controller
//   en           out  one-cycle issue strobe
//   busy         out  high in ISSUE, WAIT_ACK and HOLD
//   pending[3:0] out  latched, not-yet-served requests
//   served[3:0]  out  one-cycle pulse on the acknowledged direction
//   timeout_err  out  one-cycle pulse when an attempt is abandoned
// -----------------------------------------------------------------------------

// One pending bit per direction. A set and a clear landing in the same cycle
// resolve to set, so a request re-raised during its own acknowledge is kept.
module atc_req_lane (
  input  logic clk,
  input  logic reset,
  input  logic set_i,
  input  logic clr_i,
  output logic pend_o
);
  logic pend_q, pend_d;

  assign pend_d = set_i | (pend_q & ~clr_i);

  always_ff @(posedge clk) begin
    if (reset) pend_q <= 1'b0;
    else       pend_q <= pend_d;
  end

  assign pend_o = pend_q;
endmodule

module atc_request_sequencer #(
  parameter int ACK_TIMEOUT = 8,  // 1..255
  parameter int HOLD_CYCLES = 4   // 1..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] signal,
  output logic [1:0] d,
  output logic       en,
  output logic       busy,
  output logic [3:0] pending,
  output logic [3:0] served,
  output logic       timeout_err
);
  localparam int NUM_DIR = 4;

  // Terminal counts for the shared 8-bit counter.
  localparam logic [7:0] ACK_LAST  = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    HOLD     = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic [3:0] served_q, served_d;
  logic       tmo_q, tmo_d;
  logic [1:0] rr_q, rr_d;
  logic [7:0] cnt_q, cnt_d;

  logic [NUM_DIR-1:0] pend_clr;
  logic [NUM_DIR-1:0] pend_vec;
  logic [1:0]         sel_idx;
  logic [3:0]         dir_onehot;
  logic               ack_hit;

  // ---------------------------------------------------------------------------
  // Pending set, one lane per direction
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_DIR; g++) begin : g_lane
    atc_req_lane u_lane (
      .clk    (clk),
      .reset  (reset),
      .set_i  (req[g]),
      .clr_i  (pend_clr[g]),
      .pend_o (pend_vec[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: walk offsets from the far end toward rr_q so the
  // direction closest to rr_q (going upward, wrapping) is the last one written.
  // Only consumed in IDLE, where pend_vec is known non-zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_idx = rr_q;
    for (int i = NUM_DIR - 1; i >= 0; i--) begin
      if (pend_vec[rr_q + 2'(i)]) sel_idx = rr_q + 2'(i);
    end
  end

  assign dir_onehot = 4'b0001 << dir_q;
  // Exact match only: zero, wrong-bit and multi-hot values all miss.
  assign ack_hit    = (signal == dir_onehot);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    en_d     = 1'b0;
    busy_d   = busy_q;
    served_d = 4'b0000;
    tmo_d    = 1'b0;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    pend_clr = '0;

    unique case (state_q)
      IDLE: begin
        if (|pend_vec) begin
          state_d = ISSUE;
          dir_d   = sel_idx;
          en_d    = 1'b1;   // registered, so en is high exactly in ISSUE
          busy_d  = 1'b1;
        end
      end

      ISSUE: begin
        // signal is not looked at here; an ack coincident with en is lost.
        state_d = WAIT_ACK;
        cnt_d   = 8'd0;
      end

      WAIT_ACK: begin
        if (ack_hit) begin
          served_d = dir_onehot;
          pend_clr = dir_onehot;
          rr_d     = dir_q + 2'd1;
          cnt_d    = 8'd0;
          state_d  = HOLD;
        end else if (cnt_q == ACK_LAST) begin
          // Abandon: request stays pending, pointer moves on so other
          // directions get a turn before this one is retried.
          tmo_d   = 1'b1;
          rr_d    = dir_q + 2'd1;
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      dir_q    <= 2'd0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      served_q <= 4'b0000;
      tmo_q    <= 1'b0;
      rr_q     <= 2'd0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      served_q <= served_d;
      tmo_q    <= tmo_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign d           = dir_q;
  assign en          = en_q;
  assign busy        = busy_q;
  assign pending     = pend_vec;
  assign served      = served_q;
  assign timeout_err = tmo_q;

  // Handshake invariants seen by the controller.
  a_en_single : assert property (@(posedge clk) disable iff (reset)
    en_q |=> !en_q);
  a_en_issue  : assert property (@(posedge clk) disable iff (reset)
    en_q |-> (state_q == ISSUE));
  a_busy_mode : assert property (@(posedge clk) disable iff (reset)
    busy_q == (state_q != IDLE));

endmodule

// File: doc/atc_request_sequencer.md
Name: atc_request_sequencer

Overview:
- Initiator side of the direction/enable/signal interface into the air-traffic controller.
- Latches per-direction aircraft requests and picks one pending direction by round-robin.
- Drives it to the controller as a one-cycle `en` strobe with `d`, then waits for the controller's one-hot `signal` acknowledge.
- After the acknowledge it holds the corridor for a fixed clearance time before serving the next request; missing acknowledges are timed out and reported.

Parameters:
- ACK_TIMEOUT, 8, max cycles spent in WAIT_ACK before abandoning the attempt (range 1-255).
- HOLD_CYCLES, 4, cycles the corridor stays reserved after an acknowledge (range 1-255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  per-direction request; bit i high for one or more cycles sets pending[i].
- signal  input  4  controller acknowledge; grant of direction k is signal == (4'b0001 << k).
- d  output  2  direction presented to the controller.
- en  output  1  one-cycle issue strobe to the controller.
- busy  output  1  high in any state other than IDLE.
- pending  output  4  latched, not-yet-served requests.
- served  output  4  one-cycle pulse on bit k when direction k is acknowledged.
- timeout_err  output  1  one-cycle pulse when an attempt times out.

Behaviour:
- All outputs and state are registered.
- **Reset** (synchronous; takes priority everywhere, including mid-transaction):
  - state=IDLE, d=0, en=0, busy=0, pending=0, served=0, timeout_err=0, rr_ptr=0, counter=0.
- **Pending register:**
  - pending[i] <= 1 when req[i]=1.
  - pending[i] is cleared only on acknowledge of i.
  - If set and clear hit the same bit in the same cycle, set wins.
- **Arbitration:**
  - Round-robin over pending, searching from rr_ptr upward, wrapping 3->0.
  - Evaluated only in IDLE.
- **State IDLE:**
  - If pending != 0: next state ISSUE; d <= selected index.
  - Otherwise stay in IDLE; d holds its last value.
- **State ISSUE** (exactly 1 cycle):
  - en=1; next state WAIT_ACK; counter <= 0.
  - The cycle after a request first appears, the sequencer is in IDLE; en rises one cycle later.
  - Request-to-en latency from IDLE is therefore 2 cycles.
- **State WAIT_ACK:**
  - en=0.
  - If signal == one-hot(d): served[d] pulses next cycle; pending[d] clears; rr_ptr <= d+1 (mod 4); counter <= 0; next state HOLD.
  - Otherwise counter increments.
  - If no acknowledge has arrived when counter reaches ACK_TIMEOUT-1: timeout_err pulses next cycle; pending[d] stays set; rr_ptr <= d+1 (mod 4); next state IDLE.
  - Any non-matching signal value (zero, wrong bit, multi-hot) is ignored and counts toward the timeout.
- **State HOLD:**
  - Counter runs 0..HOLD_CYCLES-1, then next state IDLE.
  - signal is ignored.
  - New requests still latch into pending.
- **d stability:** d is stable from ISSUE through the last HOLD cycle; the controller may sample it at any point in that window.
- **en:** never asserted two cycles in a row; never asserted outside ISSUE.
- **Acknowledge timing:** an acknowledge arriving in the same cycle as en (ISSUE) is not recognised; only WAIT_ACK samples signal.
- **busy:** busy=1 in ISSUE, WAIT_ACK and HOLD.
- **Counter:** 8 bits; never wraps, because ACK_TIMEOUT and HOLD_CYCLES are at most 255.

Test Plan:
1. Reset, then req=4'b0100 for 1 cycle; controller drives signal=4'b0100 2 cycles after en -> en pulses once with d=2; served=4'b0100 pulses once; pending returns to 0; busy stays high for HOLD_CYCLES=4 cycles after the acknowledge, then IDLE.
2. req=4'b1111 in a single cycle with an always-acknowledging controller model -> service order d=0,1,2,3; exactly 4 en pulses; each pair of pulses separated by at least 1+1+4 cycles.
3. req=4'b0010 with signal held at 0 -> timeout_err pulses exactly ACK_TIMEOUT=8 cycles after the WAIT_ACK entry; pending stays 4'b0010; en is re-issued for d=1 on the next arbitration.
4. During WAIT_ACK for d=3, drive signal=4'b0001, then 4'b1001, then 4'b1000 -> only 4'b1000 is accepted; served=4'b1000.
5. Assert reset in HOLD and again in WAIT_ACK -> next cycle: busy=0, en=0, pending=0, d=0; no served or timeout_err pulse.
6. With pending[1] set, re-assert req[1] in the same cycle as its acknowledge -> pending[1] remains 1; a second en with d=1 follows the hold.
